dnn_layer: RTL and testbench

DNN_LAYER -- requirements
Module: dnn_layer

---
 rtl/dnn_layer.sv | 258 +++++++++++++++++++++++++
 tb/tb_dnn_layer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_layer.sv
// dnn_layer: one fully-connected neural-network layer with activation.
// For each output j it fetches bias[j], then N weight/input pairs over an
// Avalon-MM master, multiply-accumulates them in signed fixed point, applies
// the selected activation and writes out[j] back through the master.
//
// Ports:
//   clk, rst_n          - rising-edge clock, synchronous active-low reset
//   slave_*             - Avalon-MM configuration/status slave (word index)
//     0: write = start, read = {30'b0, done, busy}
//     1: bias base, 2: weight base, 3: input base, 4: output base
//     5: N, 6: M, 7: activation mode [1:0], 8-15: read 0
//   master_*            - Avalon-MM memory master (byte addresses)
module dnn_layer #(
  parameter int FRAC_BITS = 16,
  parameter int MAX_N     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [3:0]  slave_address,
  output logic [31:0] slave_readdata,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_REQ_BIAS = 4'd1;
  localparam logic [3:0] S_RCV_BIAS = 4'd2;
  localparam logic [3:0] S_REQ_W    = 4'd3;
  localparam logic [3:0] S_RCV_W    = 4'd4;
  localparam logic [3:0] S_REQ_IN   = 4'd5;
  localparam logic [3:0] S_RCV_IN   = 4'd6;
  localparam logic [3:0] S_MAC      = 4'd7;
  localparam logic [3:0] S_ACT      = 4'd8;
  localparam logic [3:0] S_WR_OUT   = 4'd9;

  logic [3:0]        state_r;
  logic [31:0]       bias_base_r, weight_base_r, in_base_r, out_base_r;
  logic [31:0]       n_r, m_r;
  logic [1:0]        mode_r;
  logic              busy_r, done_r;
  logic [CNT_W-1:0]  i_r;
  logic [31:0]       j_r;
  logic [31:0]       w_ptr_r;
  logic [31:0]       acc_r, w_r, x_r;
  logic              master_read_r, master_write_r;
  logic [31:0]       master_address_r, master_writedata_r;

  logic              start_s, cfg_we_s;
  logic [CNT_W-1:0]  n_eff_s, i_next_s;
  logic [31:0]       i_ext_s, j_next_s;
  logic signed [63:0] prod_s;
  logic [31:0]       mac_s, act_s;

  assign slave_waitrequest = 1'b0;
  assign master_read       = master_read_r;
  assign master_write      = master_write_r;
  assign master_address    = master_address_r;
  assign master_writedata  = master_writedata_r;

  // Configuration is frozen while a layer is running.
  assign cfg_we_s = slave_write && !busy_r;
  assign start_s  = cfg_we_s && (slave_address == 4'd0);

  // Lengths beyond MAX_N are clamped so the loop counter cannot overflow.
  assign n_eff_s  = (n_r > 32'(MAX_N)) ? CNT_W'(MAX_N) : n_r[CNT_W-1:0];
  assign i_next_s = i_r + CNT_W'(1);
  assign i_ext_s  = {{(32-CNT_W){1'b0}}, i_r};
  assign j_next_s = j_r + 32'd1;

  // Q-format product: keep the 32 bits aligned with the accumulator, wrap on add.
  assign prod_s = $signed(w_r) * $signed(x_r);
  assign mac_s  = acc_r + prod_s[FRAC_BITS+31:FRAC_BITS];

  // Activation function applied to the finished accumulator.
  always_comb begin
    act_s = acc_r;
    case (mode_r)
      2'd1:    act_s = acc_r[31] ? 32'd0 : acc_r;
      2'd2:    act_s = acc_r[31] ? 32'($signed(acc_r) >>> 2'd3) : acc_r;
      default: act_s = acc_r;
    endcase
  end

  // Slave read mux (combinational, no wait states).
  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0:    slave_readdata = {30'd0, done_r, busy_r};
      4'd1:    slave_readdata = bias_base_r;
      4'd2:    slave_readdata = weight_base_r;
      4'd3:    slave_readdata = in_base_r;
      4'd4:    slave_readdata = out_base_r;
      4'd5:    slave_readdata = n_r;
      4'd6:    slave_readdata = m_r;
      4'd7:    slave_readdata = {30'd0, mode_r};
      default: slave_readdata = 32'd0;
    endcase
  end

  // Configuration register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bias_base_r   <= 32'd0;
      weight_base_r <= 32'd0;
      in_base_r     <= 32'd0;
      out_base_r    <= 32'd0;
      n_r           <= 32'd0;
      m_r           <= 32'd0;
      mode_r        <= 2'd0;
    end else if (cfg_we_s) begin
      case (slave_address)
        4'd1:    bias_base_r   <= slave_writedata;
        4'd2:    weight_base_r <= slave_writedata;
        4'd3:    in_base_r     <= slave_writedata;
        4'd4:    out_base_r    <= slave_writedata;
        4'd5:    n_r           <= slave_writedata;
        4'd6:    m_r           <= slave_writedata;
        4'd7:    mode_r        <= slave_writedata[1:0];
        default: ;
      endcase
    end
  end

  // Layer sequencer; master outputs are registered and set on entry to each REQ/WR state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r            <= S_IDLE;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
      i_r                <= '0;
      j_r                <= 32'd0;
      w_ptr_r            <= 32'd0;
      acc_r              <= 32'd0;
      w_r                <= 32'd0;
      x_r                <= 32'd0;
      master_read_r      <= 1'b0;
      master_write_r     <= 1'b0;
      master_address_r   <= 32'd0;
      master_writedata_r <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // busy set while idle only happens for M=0: finish after one cycle.
          if (busy_r) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else if (start_s) begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            j_r     <= 32'd0;
            w_ptr_r <= weight_base_r;
            if (m_r != 32'd0) begin
              state_r          <= S_REQ_BIAS;
              master_read_r    <= 1'b1;
              master_address_r <= bias_base_r;
            end
          end
        end
        S_REQ_BIAS: begin
          if (!master_waitrequest) begin
            master_read_r <= 1'b0;
            state_r       <= S_RCV_BIAS;
          end
        end
        S_RCV_BIAS: begin
          if (master_readdatavalid) begin
            acc_r <= master_readdata;
            i_r   <= '0;
            if (n_eff_s == '0) begin
              state_r <= S_ACT;
            end else begin
              state_r          <= S_REQ_W;
              master_read_r    <= 1'b1;
              master_address_r <= w_ptr_r;
            end
          end
        end
        S_REQ_W: begin
          if (!master_waitrequest) begin
            master_read_r <= 1'b0;
            state_r       <= S_RCV_W;
          end
        end
        S_RCV_W: begin
          if (master_readdatavalid) begin
            w_r              <= master_readdata;
            w_ptr_r          <= w_ptr_r + 32'd4;
            state_r          <= S_REQ_IN;
            master_read_r    <= 1'b1;
            master_address_r <= in_base_r + {i_ext_s[29:0], 2'b00};
          end
        end
        S_REQ_IN: begin
          if (!master_waitrequest) begin
            master_read_r <= 1'b0;
            state_r       <= S_RCV_IN;
          end
        end
        S_RCV_IN: begin
          if (master_readdatavalid) begin
            x_r     <= master_readdata;
            state_r <= S_MAC;
          end
        end
        S_MAC: begin
          acc_r <= mac_s;
          i_r   <= i_next_s;
          if (i_next_s == n_eff_s) begin
            state_r <= S_ACT;
          end else begin
            // Weights for consecutive j are contiguous, so w_ptr just keeps counting.
            state_r          <= S_REQ_W;
            master_read_r    <= 1'b1;
            master_address_r <= w_ptr_r;
          end
        end
        S_ACT: begin
          master_writedata_r <= act_s;
          master_address_r   <= out_base_r + {j_r[29:0], 2'b00};
          master_write_r     <= 1'b1;
          state_r            <= S_WR_OUT;
        end
        S_WR_OUT: begin
          if (!master_waitrequest) begin
            master_write_r <= 1'b0;
            if (j_next_s == m_r) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              j_r              <= j_next_s;
              state_r          <= S_REQ_BIAS;
              master_read_r    <= 1'b1;
              master_address_r <= bias_base_r + {j_next_s[29:0], 2'b00};
            end
          end
        end
        default: begin
          state_r        <= S_IDLE;
          master_read_r  <= 1'b0;
          master_write_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_layer.sv
// tb_dnn_layer: directed bench for dnn_layer with a small Avalon-MM memory
// model (programmable waitrequest length and read latency) and a write log.
module tb_dnn_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slave_waitrequest;
  logic        slave_read, slave_write;
  logic [3:0]  slave_address;
  logic [31:0] slave_readdata, slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  always #5 clk = ~clk;

  dnn_layer #(.FRAC_BITS(16), .MAX_N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(slave_waitrequest), .slave_read(slave_read),
    .slave_write(slave_write), .slave_address(slave_address),
    .slave_readdata(slave_readdata), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_write(master_write),
    .master_writedata(master_writedata)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [256];
  int          wr_dly = 0;
  int          rd_lat = 0;
  int          wcnt = 0;
  logic        pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] pdata = 32'd0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  int          rd_cnt [4] = '{0, 0, 0, 0};
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];

  assign master_waitrequest   = (master_read || master_write) && (wcnt < wr_dly);
  assign master_readdatavalid = rvalid;
  assign master_readdata      = rdata;

  always @(posedge clk) begin
    rvalid <= 1'b0;
    if (pend) begin
      if (pcnt == 0) begin
        rvalid <= 1'b1;
        rdata  <= pdata;
        pend   <= 1'b0;
      end else begin
        pcnt <= pcnt - 1;
      end
    end
    if (master_read || master_write) begin
      if (master_waitrequest) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (master_write) begin
          wlog_addr.push_back(master_address);
          wlog_data.push_back(master_writedata);
        end else begin
          pend  <= 1'b1;
          pcnt  <= rd_lat;
          pdata <= mem[master_address[9:2]];
          rd_cnt[master_address[9:8]] <= rd_cnt[master_address[9:8]] + 1;
        end
      end
    end
  end

  // Bus-protocol monitor: held request must keep its address; never read and write at once.
  logic        hold_v = 1'b0;
  logic [31:0] hold_addr = 32'd0;
  always @(negedge clk) begin
    if (master_read || master_write)
      check_eq("rw_excl", {31'd0, master_read && master_write}, 32'd0);
    if (hold_v && (master_read || master_write))
      check_eq("addr_stable", master_address, hold_addr);
    hold_v    = master_waitrequest && (master_read || master_write);
    hold_addr = master_address;
  end

  // ---------------- slave access ----------------
  task automatic slv_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_write = 1'b1; slave_address = a; slave_writedata = d;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic slv_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    #1 d = slave_readdata;
    slave_read = 1'b0;
  endtask

  task automatic configure(input logic [31:0] n, input logic [31:0] m, input logic [31:0] mode);
    slv_write(4'd1, 32'h0000_0000);
    slv_write(4'd2, 32'h0000_0100);
    slv_write(4'd3, 32'h0000_0200);
    slv_write(4'd4, 32'h0000_0300);
    slv_write(4'd5, n);
    slv_write(4'd6, m);
    slv_write(4'd7, mode);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] st;
    st = 32'd0;
    for (int k = 0; k < 3000; k++) begin
      slv_read(4'd0, st);
      if (st[1]) break;
    end
    check_eq(tag, st, 32'd2);
  endtask

  task automatic run_layer(input string tag, input logic [31:0] n, input logic [31:0] m,
                           input logic [31:0] mode);
    configure(n, m, mode);
    slv_write(4'd0, 32'd1);
    wait_done(tag);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wlog_addr.size()) begin
      check_eq({tag, "_addr"}, wlog_addr[idx], a);
      check_eq({tag, "_data"}, wlog_data[idx], d);
    end else begin
      check_eq({tag, "_present"}, 32'd0, 32'd1);
    end
  endtask

  task automatic load_fc_case;
    mem[0]   = 32'h0001_0000;
    mem[64]  = 32'h0002_0000;
    mem[65]  = 32'h0003_0000;
    mem[128] = 32'h0000_8000;
    mem[129] = 32'hFFFF_0000;
  endtask

  int w0, rw0, ri0;
  logic [31:0] rd;
  logic [31:0] exp_mode [3] = '{32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_E000};
  int found;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    rst_n = 1'b0; slave_read = 1'b0; slave_write = 1'b0;
    slave_address = 4'd0; slave_writedata = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_mread", {31'd0, master_read}, 32'd0);
    check_eq("rst_mwrite", {31'd0, master_write}, 32'd0);
    check_eq("rst_maddr", master_address, 32'd0);
    check_eq("rst_swait", {31'd0, slave_waitrequest}, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      slv_read(4'(a), rd);
      check_eq("rst_reg", rd, 32'd0);
    end
    slv_write(4'd9, 32'h1234_5678);
    slv_read(4'd9, rd);
    check_eq("reg9_zero", rd, 32'd0);

    // Basic layer in all three activation modes
    load_fc_case();
    for (int md = 0; md < 3; md++) begin
      w0 = wlog_addr.size();
      run_layer("fc_done", 32'd2, 32'd1, 32'(md));
      check_eq("fc_nwr", 32'(wlog_addr.size() - w0), 32'd1);
      check_wr("fc_wr", w0, 32'h0000_0300, exp_mode[md]);
    end
    slv_read(4'd5, rd);
    check_eq("reg5_readback", rd, 32'd2);
    slv_read(4'd7, rd);
    check_eq("reg7_readback", rd, 32'd2);

    // Slow memory: waitrequest 2 cycles, readdatavalid 3 cycles late
    for (int k = 0; k < 3; k++) begin
      mem[k] = 32'h0001_0000; mem[64+k] = 32'h0001_0000;
    end
    mem[128] = 32'h0001_0000;
    wr_dly = 2; rd_lat = 3;
    w0 = wlog_addr.size(); rw0 = rd_cnt[1]; ri0 = rd_cnt[2];
    run_layer("slow_done", 32'd1, 32'd3, 32'd0);
    check_eq("slow_nwr", 32'(wlog_addr.size() - w0), 32'd3);
    for (int k = 0; k < 3; k++)
      check_wr("slow_wr", w0 + k, 32'h0000_0300 + 32'(4*k), 32'h0002_0000);
    check_eq("slow_wreads", 32'(rd_cnt[1] - rw0), 32'd3);
    check_eq("slow_ireads", 32'(rd_cnt[2] - ri0), 32'd3);
    wr_dly = 0; rd_lat = 0;

    // N=0: bias only, ReLU
    mem[0] = 32'd5; mem[1] = 32'hFFFF_FFFB;
    w0 = wlog_addr.size(); rw0 = rd_cnt[1]; ri0 = rd_cnt[2];
    run_layer("n0_done", 32'd0, 32'd2, 32'd1);
    check_eq("n0_nwr", 32'(wlog_addr.size() - w0), 32'd2);
    check_wr("n0_wr0", w0, 32'h0000_0300, 32'd5);
    check_wr("n0_wr1", w0 + 1, 32'h0000_0304, 32'd0);
    check_eq("n0_wreads", 32'(rd_cnt[1] - rw0), 32'd0);
    check_eq("n0_ireads", 32'(rd_cnt[2] - ri0), 32'd0);

    // M=0: busy exactly one cycle, no traffic
    w0 = wlog_addr.size(); rw0 = rd_cnt[0];
    configure(32'd2, 32'd0, 32'd0);
    slv_write(4'd0, 32'd1);
    slave_address = 4'd0;
    #1 check_eq("m0_busy", slave_readdata, 32'd1);
    @(negedge clk);
    #1 check_eq("m0_done", slave_readdata, 32'd2);
    repeat (3) @(negedge clk);
    #1 check_eq("m0_done_hold", slave_readdata, 32'd2);
    check_eq("m0_nwr", 32'(wlog_addr.size() - w0), 32'd0);
    check_eq("m0_breads", 32'(rd_cnt[0] - rw0), 32'd0);

    // N > MAX_N clamps to 8 terms
    mem[0] = 32'd0;
    for (int k = 0; k < 10; k++) begin
      mem[64+k] = 32'h0001_0000; mem[128+k] = 32'h0001_0000;
    end
    w0 = wlog_addr.size(); rw0 = rd_cnt[1];
    run_layer("clamp_done", 32'd10, 32'd1, 32'd0);
    check_wr("clamp_wr", w0, 32'h0000_0300, 32'h0008_0000);
    check_eq("clamp_wreads", 32'(rd_cnt[1] - rw0), 32'd8);

    // Start and config writes while busy are ignored
    load_fc_case();
    wr_dly = 1; rd_lat = 2;
    w0 = wlog_addr.size();
    configure(32'd2, 32'd1, 32'd0);
    slv_write(4'd0, 32'd1);
    slv_write(4'd5, 32'd7);
    slv_write(4'd0, 32'd1);
    wait_done("busy_done");
    check_eq("busy_nwr", 32'(wlog_addr.size() - w0), 32'd1);
    check_wr("busy_wr", w0, 32'h0000_0300, 32'hFFFF_0000);
    slv_read(4'd5, rd);
    check_eq("busy_reg5", rd, 32'd2);

    // Reset while waiting for a weight
    wr_dly = 0; rd_lat = 20;
    w0 = wlog_addr.size();
    slv_write(4'd0, 32'd1);
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (master_read && !master_waitrequest && master_address[9:8] == 2'd1) begin
        found = 1;
        break;
      end
    end
    check_eq("rcvw_reached", 32'(found), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rstx_mread", {31'd0, master_read}, 32'd0);
    check_eq("rstx_mwrite", {31'd0, master_write}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      slv_read(4'(a), rd);
      check_eq("rstx_reg", rd, 32'd0);
    end
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check_eq("late_mread", {31'd0, master_read}, 32'd0);
    slv_read(4'd0, rd);
    check_eq("late_status", rd, 32'd0);
    check_eq("late_nwr", 32'(wlog_addr.size() - w0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
